// File: rtl/cakegame_fd.sv
// Datapath for the cakegame memory game: sequence RAM, LFSR, counters, button edge detector, LED mux.
// Optional debug taps are enabled by defining CAKEGAME_FD_DEBUG_EN.
module cakegame_fd #(
  parameter int         MEM_DEPTH      = 16,
  parameter int         ADDR_W         = 4,
  parameter int         SHOW_CYCLES    = 1000,
  parameter int         TIMEOUT_CYCLES = 5000,
  parameter int         POINTS_W       = 5,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          buttons,
  input  logic [1:0]          out_sel,
  input  logic                clear_reg,
  input  logic                enable_reg,
  input  logic                clear_mem_counter,
  input  logic                enable_mem_counter,
  input  logic                clear_show_counter,
  input  logic                enable_show_counter,
  input  logic                enable_timeout_counter,
  input  logic                clear_points_counter,
  input  logic                enable_points_counter,
  input  logic                clear_ram,
  input  logic                enable_ram,
  input  logic                reset_random,
  output logic                end_mem_counter,
  output logic                correct_play,
  output logic                has_play,
  output logic                half_show,
  output logic                end_show,
  output logic                timeout,
  output logic [3:0]          leds,
  output logic [POINTS_W-1:0] points
`ifdef CAKEGAME_FD_DEBUG_EN
  ,
  output logic [ADDR_W-1:0]   db_address,
  output logic [3:0]          db_play,
  output logic [3:0]          db_expected,
  output logic [7:0]          db_lfsr
`endif
);

  localparam int SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]          SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [ADDR_W-1:0]   ADDR_LAST  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [SHOW_W-1:0]   SHOW_LAST  = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [SHOW_W-1:0]   SHOW_HALF  = SHOW_W'(SHOW_CYCLES / 2 - 1);
  localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [POINTS_W-1:0] POINTS_MAX = {POINTS_W{1'b1}};

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SHOW_W-1:0]   show_q, show_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [POINTS_W-1:0] points_q, points_d;
  logic [3:0]          play_q, play_d;
  logic [3:0]          buttons_q, buttons_d;
  logic [3:0]          last_press_q, last_press_d;
  logic                has_play_q, has_play_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [3:0]          leds_q, leds_d;
  logic [3:0]          ram_q [MEM_DEPTH];
  logic [3:0]          ram_d [MEM_DEPTH];
  logic [3:0]          rand_play;
  logic [3:0]          expected;
  logic                new_press;

  assign expected  = ram_q[addr_q];
  assign rand_play = 4'b0001 << lfsr_q[1:0];
  assign new_press = (|buttons) & ~(|buttons_q);

  // Counters: clear takes priority over enable.
  always_comb begin
    addr_d = addr_q;
    if (clear_mem_counter) addr_d = '0;
    else if (enable_mem_counter) addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
    else addr_d = addr_q;

    show_d = show_q;
    if (clear_show_counter) show_d = '0;
    else if (enable_show_counter) show_d = (show_q == SHOW_LAST) ? '0 : show_q + SHOW_W'(1);
    else show_d = show_q;

    // A fresh press restarts the idle window; the count parks at the limit.
    to_d = '0;
    if (enable_timeout_counter && !has_play_q) to_d = (to_q == TO_LAST) ? to_q : to_q + TO_W'(1);
    else to_d = '0;

    points_d = points_q;
    if (clear_points_counter) points_d = '0;
    else if (enable_points_counter && (points_q != POINTS_MAX)) points_d = points_q + POINTS_W'(1);
    else points_d = points_q;
  end

  // Button history, play register and LFSR.
  always_comb begin
    buttons_d    = buttons;
    has_play_d   = new_press;
    last_press_d = new_press ? buttons : last_press_q;

    play_d = play_q;
    if (clear_reg) play_d = 4'b0000;
    else if (enable_reg) play_d = last_press_q;
    else play_d = play_q;

    lfsr_d = lfsr_q;
    if (reset_random) lfsr_d = SEED;
    else lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Sequence RAM next state and LED source mux.
  always_comb begin
    for (int i = 0; i < MEM_DEPTH; i++) begin
      ram_d[i] = clear_ram ? 4'b0000
               : (enable_ram && (addr_q == ADDR_W'(i))) ? rand_play : ram_q[i];
    end
    case (out_sel)
      2'b00:   leds_d = 4'b0000;
      2'b01:   leds_d = expected;
      2'b10:   leds_d = buttons;
      2'b11:   leds_d = 4'b0000;
      default: leds_d = 4'b0000;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q       <= '0;
      show_q       <= '0;
      to_q         <= '0;
      points_q     <= '0;
      play_q       <= 4'b0000;
      buttons_q    <= 4'b0000;
      last_press_q <= 4'b0000;
      has_play_q   <= 1'b0;
      lfsr_q       <= SEED;
      leds_q       <= 4'b0000;
      for (int i = 0; i < MEM_DEPTH; i++) ram_q[i] <= 4'b0000;
    end else begin
      addr_q       <= addr_d;
      show_q       <= show_d;
      to_q         <= to_d;
      points_q     <= points_d;
      play_q       <= play_d;
      buttons_q    <= buttons_d;
      last_press_q <= last_press_d;
      has_play_q   <= has_play_d;
      lfsr_q       <= lfsr_d;
      leds_q       <= leds_d;
      for (int i = 0; i < MEM_DEPTH; i++) ram_q[i] <= ram_d[i];
    end
  end

  assign end_mem_counter = (addr_q == ADDR_LAST);
  assign correct_play    = (play_q == expected);
  assign has_play        = has_play_q;
  assign half_show       = (show_q == SHOW_HALF);
  assign end_show        = (show_q == SHOW_LAST);
  assign timeout         = enable_timeout_counter & (to_q == TO_LAST) & ~has_play_q;
  assign leds            = leds_q;
  assign points          = points_q;

`ifdef CAKEGAME_FD_DEBUG_EN
  assign db_address  = addr_q;
  assign db_play     = play_q;
  assign db_expected = expected;
  assign db_lfsr     = lfsr_q;
`endif

endmodule

// File: tb/tb_cakegame_fd.sv
// Self-checking bench for cakegame_fd: directed steps plus randomized strobes against a behavioural model.
module tb_cakegame_fd;
  localparam int         MD   = 4;
  localparam int         SC   = 8;
  localparam int         TC   = 10;
  localparam int         PW   = 3;
  localparam int         PMAX = 7;
  localparam logic [7:0] SEED = 8'hA5;

  logic clock = 1'b0;
  logic reset, clear_reg, enable_reg, clear_mem_counter, enable_mem_counter;
  logic clear_show_counter, enable_show_counter, enable_timeout_counter;
  logic clear_points_counter, enable_points_counter, clear_ram, enable_ram, reset_random;
  logic [3:0] buttons;
  logic [1:0] out_sel;
  logic end_mem_counter, correct_play, has_play, half_show, end_show, timeout;
  logic [3:0] leds;
  logic [PW-1:0] points;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_addr, m_show, m_to, m_points;
  logic [3:0] m_play, m_lp, m_bq, m_leds;
  logic [3:0] m_ram [MD];
  logic [7:0] m_lfsr;
  bit m_hp;

  always #5 clock = ~clock;

  cakegame_fd #(.MEM_DEPTH(MD), .ADDR_W(2), .SHOW_CYCLES(SC), .TIMEOUT_CYCLES(TC),
                .POINTS_W(PW), .LFSR_SEED(SEED)) dut (
    .clock(clock), .reset(reset), .buttons(buttons), .out_sel(out_sel),
    .clear_reg(clear_reg), .enable_reg(enable_reg),
    .clear_mem_counter(clear_mem_counter), .enable_mem_counter(enable_mem_counter),
    .clear_show_counter(clear_show_counter), .enable_show_counter(enable_show_counter),
    .enable_timeout_counter(enable_timeout_counter),
    .clear_points_counter(clear_points_counter), .enable_points_counter(enable_points_counter),
    .clear_ram(clear_ram), .enable_ram(enable_ram), .reset_random(reset_random),
    .end_mem_counter(end_mem_counter), .correct_play(correct_play), .has_play(has_play),
    .half_show(half_show), .end_show(end_show), .timeout(timeout),
    .leds(leds), .points(points));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  task automatic check_all();
    chk("end_mem_counter", {31'd0, end_mem_counter}, (m_addr == MD - 1) ? 32'd1 : 32'd0);
    chk("correct_play", {31'd0, correct_play}, (m_play == m_ram[m_addr]) ? 32'd1 : 32'd0);
    chk("has_play", {31'd0, has_play}, {31'd0, m_hp});
    chk("half_show", {31'd0, half_show}, (m_show == SC / 2 - 1) ? 32'd1 : 32'd0);
    chk("end_show", {31'd0, end_show}, (m_show == SC - 1) ? 32'd1 : 32'd0);
    chk("timeout", {31'd0, timeout},
        (enable_timeout_counter && m_to == TC - 1 && !m_hp) ? 32'd1 : 32'd0);
    chk("leds", {28'd0, leds}, {28'd0, m_leds});
    chk("points", {29'd0, points}, m_points);
  endtask

  // One clock edge: advance the model from the current inputs, then compare everything.
  task automatic tick();
    int n_addr, n_show, n_to, n_points;
    logic [3:0] n_play, n_lp, n_leds;
    logic [3:0] n_ram [MD];
    logic [7:0] n_lfsr;
    bit n_hp;
    n_ram = m_ram;
    if (reset) begin
      n_addr = 0; n_show = 0; n_to = 0; n_points = 0;
      n_play = 4'd0; n_lp = 4'd0; n_leds = 4'd0; n_hp = 1'b0; n_lfsr = SEED;
      for (int i = 0; i < MD; i++) n_ram[i] = 4'd0;
    end else begin
      n_addr   = clear_mem_counter ? 0 : enable_mem_counter ? (m_addr + 1) % MD : m_addr;
      n_show   = clear_show_counter ? 0 : enable_show_counter ? (m_show + 1) % SC : m_show;
      n_to     = (enable_timeout_counter && !m_hp) ? ((m_to + 1 > TC - 1) ? TC - 1 : m_to + 1) : 0;
      n_points = clear_points_counter ? 0
               : enable_points_counter ? ((m_points + 1 > PMAX) ? PMAX : m_points + 1) : m_points;
      n_play   = clear_reg ? 4'd0 : enable_reg ? m_lp : m_play;
      n_hp     = (buttons != 4'd0) && (m_bq == 4'd0);
      n_lp     = n_hp ? buttons : m_lp;
      n_lfsr   = reset_random ? SEED : lfsr_next(m_lfsr);
      if (clear_ram) for (int i = 0; i < MD; i++) n_ram[i] = 4'd0;
      else if (enable_ram) n_ram[m_addr] = 4'd1 << m_lfsr[1:0];
      n_leds = (out_sel == 2'b01) ? m_ram[m_addr] : (out_sel == 2'b10) ? buttons : 4'd0;
    end
    @(posedge clock);
    #1;
    m_addr = n_addr; m_show = n_show; m_to = n_to; m_points = n_points;
    m_play = n_play; m_lp = n_lp; m_leds = n_leds; m_hp = n_hp; m_lfsr = n_lfsr;
    m_bq = reset ? 4'd0 : buttons;
    m_ram = n_ram;
    check_all();
  endtask

  task automatic idle_inputs();
    clear_reg = 1'b0; enable_reg = 1'b0; clear_mem_counter = 1'b0; enable_mem_counter = 1'b0;
    clear_show_counter = 1'b0; enable_show_counter = 1'b0; enable_timeout_counter = 1'b0;
    clear_points_counter = 1'b0; enable_points_counter = 1'b0; clear_ram = 1'b0;
    enable_ram = 1'b0; reset_random = 1'b0; buttons = 4'd0; out_sel = 2'b00;
  endtask

  initial begin
    logic [3:0] exp_ram [MD];
    logic [7:0] l;
    int pulses;

    idle_inputs();
    reset = 1'b1;
    m_bq = 4'd0; m_lfsr = SEED; m_hp = 1'b0;
    tick(); tick();
    chk("rst_leds", {28'd0, leds}, 32'd0);
    chk("rst_points", {29'd0, points}, 32'd0);
    chk("rst_has_play", {31'd0, has_play}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_end_mem", {31'd0, end_mem_counter}, 32'd0);
    chk("rst_correct", {31'd0, correct_play}, 32'd1);
    reset = 1'b0;

    // Show counter markers and wrap
    clear_show_counter = 1'b1; tick(); clear_show_counter = 1'b0;
    enable_show_counter = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("show_half_seq", {31'd0, half_show}, ((k % SC) == 3) ? 32'd1 : 32'd0);
      chk("show_end_seq", {31'd0, end_show}, ((k % SC) == 7) ? 32'd1 : 32'd0);
    end
    clear_show_counter = 1'b1; tick(); clear_show_counter = 1'b0;
    chk("show_clr_wins_half", {31'd0, half_show}, 32'd0);
    tick(); tick(); tick();
    chk("show_after_clr", {31'd0, half_show}, 32'd1);
    enable_show_counter = 1'b0; tick();
    chk("show_hold", {31'd0, half_show}, 32'd1);

    // RAM fill from the LFSR and readback through the LED mux
    reset_random = 1'b1; clear_mem_counter = 1'b1; tick();
    reset_random = 1'b0; clear_mem_counter = 1'b0;
    l = SEED;
    for (int i = 0; i < MD; i++) begin
      exp_ram[i] = 4'd1 << l[1:0];
      l = lfsr_next(l);
    end
    enable_ram = 1'b1; enable_mem_counter = 1'b1;
    repeat (MD) tick();
    enable_ram = 1'b0; out_sel = 2'b01;
    for (int j = 0; j < MD; j++) begin
      tick();
      chk("leds_ram", {28'd0, leds}, {28'd0, exp_ram[j]});
    end
    enable_mem_counter = 1'b0; out_sel = 2'b00; tick();
    chk("leds_off", {28'd0, leds}, 32'd0);

    // Single edge detection and play compare (ram[0] is 0010 for this seed)
    buttons = 4'b0010; pulses = 0;
    repeat (5) begin tick(); pulses += int'(has_play); end
    buttons = 4'b0000;
    repeat (2) begin tick(); pulses += int'(has_play); end
    chk("has_play_pulses", pulses, 32'd1);
    enable_reg = 1'b1; tick(); enable_reg = 1'b0;
    chk("correct_play_match", {31'd0, correct_play}, 32'd1);
    enable_mem_counter = 1'b1; tick(); enable_mem_counter = 1'b0;
    chk("correct_play_addr1", {31'd0, correct_play}, (exp_ram[1] == 4'b0010) ? 32'd1 : 32'd0);

    // Points count and saturation
    clear_points_counter = 1'b1; tick(); clear_points_counter = 1'b0;
    enable_points_counter = 1'b1; tick(); tick(); enable_points_counter = 1'b0;
    chk("points_two", {29'd0, points}, 32'd2);
    enable_points_counter = 1'b1; repeat (8) tick(); enable_points_counter = 1'b0;
    chk("points_sat", {29'd0, points}, 32'd7);

    // Timeout reaches the limit and holds
    enable_timeout_counter = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("timeout_seq", {31'd0, timeout}, (k >= TC - 1) ? 32'd1 : 32'd0);
    end
    enable_timeout_counter = 1'b0; tick();
    chk("timeout_off", {31'd0, timeout}, 32'd0);

    // A press part-way through restarts the idle window
    enable_timeout_counter = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 5) buttons = 4'b0001;
      if (k == 6) buttons = 4'b0000;
      if (k == 9) chk("timeout_delayed", {31'd0, timeout}, 32'd0);
      if (k == 15) chk("timeout_not_yet", {31'd0, timeout}, 32'd0);
      if (k == 16) chk("timeout_late", {31'd0, timeout}, 32'd1);
    end
    enable_timeout_counter = 1'b0; tick();

    // Clear wins over a simultaneous write
    enable_ram = 1'b1; clear_ram = 1'b1; tick();
    enable_ram = 1'b0; clear_ram = 1'b0;
    out_sel = 2'b01; enable_mem_counter = 1'b1;
    repeat (MD) begin tick(); chk("ram_cleared", {28'd0, leds}, 32'd0); end
    idle_inputs(); tick();

    // Reset in the middle of activity
    enable_show_counter = 1'b1; enable_points_counter = 1'b1; enable_mem_counter = 1'b1;
    enable_timeout_counter = 1'b1; out_sel = 2'b10; buttons = 4'b1000;
    repeat (3) tick();
    reset = 1'b1; tick();
    chk("midrst_points", {29'd0, points}, 32'd0);
    chk("midrst_leds", {28'd0, leds}, 32'd0);
    chk("midrst_half", {31'd0, half_show}, 32'd0);
    chk("midrst_end_mem", {31'd0, end_mem_counter}, 32'd0);
    chk("midrst_has_play", {31'd0, has_play}, 32'd0);
    reset = 1'b0; idle_inputs(); tick();

    // Randomized strobes against the model
    for (int c = 0; c < 600; c++) begin
      clear_reg = ($urandom_range(0, 15) == 0);
      enable_reg = ($urandom_range(0, 3) == 0);
      clear_mem_counter = ($urandom_range(0, 15) == 0);
      enable_mem_counter = ($urandom_range(0, 1) == 0);
      clear_show_counter = ($urandom_range(0, 31) == 0);
      enable_show_counter = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) enable_timeout_counter = ~enable_timeout_counter;
      clear_points_counter = ($urandom_range(0, 31) == 0);
      enable_points_counter = ($urandom_range(0, 3) == 0);
      clear_ram = ($urandom_range(0, 31) == 0);
      enable_ram = ($urandom_range(0, 2) == 0);
      reset_random = ($urandom_range(0, 31) == 0);
      out_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        buttons = ($urandom_range(0, 2) == 0) ? 4'd0
                : ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                : (4'd1 << $urandom_range(0, 3));
      reset = ($urandom_range(0, 127) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cakegame_fd.md
Name: cakegame_fd

Overview:
- Datapath for the cakegame memory game, driven by the game control unit.
- Takes that unit's clear/enable strobes and returns its status inputs: end_mem_counter, correct_play, has_play, end_show, half_show, timeout.
- Holds the random play sequence RAM, address, show, timeout and points counters, play register, button edge detector and LED output mux.

Parameters:
- MEM_DEPTH, 16, plays per round; sequence RAM depth.
- ADDR_W, 4, address width; MEM_DEPTH <= 2**ADDR_W.
- SHOW_CYCLES, 1000, clocks per show period (on plus interval); even, >= 4.
- TIMEOUT_CYCLES, 5000, idle clocks allowed per play.
- POINTS_W, 5, points width; holds MEM_DEPTH.
- LFSR_SEED, 8'hA5, random seed; a value of 0 is replaced by 8'h01.

Ports:
- clock in 1: rising-edge clock.
- reset in 1: synchronous, active-high reset.
- buttons in 4: player buttons, already synchronized; a play is exactly one bit set.
- out_sel in 2: LED source select.
- clear_reg, enable_reg in 1 each: play register clear/load.
- clear_mem_counter, enable_mem_counter in 1 each: address counter.
- clear_show_counter, enable_show_counter in 1 each: show counter.
- enable_timeout_counter in 1: timeout counter run.
- clear_points_counter, enable_points_counter in 1 each: points counter.
- clear_ram, enable_ram in 1 each: RAM clear and write.
- reset_random in 1: reload the LFSR.
- end_mem_counter out 1: address == MEM_DEPTH-1.
- correct_play out 1: play register == ram[address].
- has_play out 1: one-cycle pulse on a new press.
- half_show, end_show out 1 each: show counter markers.
- timeout out 1: idle limit reached.
- leds out 4: registered LED drive.
- points out POINTS_W: correct plays this round.

Behaviour:
- Reset clears every register to 0: address, show count, timeout count, points, play register, all RAM words, leds, button history and last_press. The LFSR loads the seed. Status outputs follow the cleared state: end_mem_counter=(MEM_DEPTH==1), correct_play=1 (0==0), all others 0.
- Counter priority: clear beats enable when both are asserted in the same cycle.
- Address counter: enable gives +1, wrapping from MEM_DEPTH-1 to 0. end_mem_counter is combinational.
- Show counter: enable gives +1, wrapping from SHOW_CYCLES-1 to 0; it holds when enable is low.
  - half_show = (count == SHOW_CYCLES/2-1).
  - end_show = (count == SHOW_CYCLES-1).
  - Both are combinational and are not gated by enable.
- Timeout counter: counts while enable_timeout_counter=1 and has_play=0; otherwise it is forced to 0.
  - timeout = enable_timeout_counter and (count == TIMEOUT_CYCLES-1).
  - At the limit the count holds.
  - has_play and the limit in the same cycle: timeout is suppressed that cycle.
- Button edge detector:
  - buttons_q is a 1-cycle registered copy of buttons.
  - A new press is (|buttons) & ~(|buttons_q).
  - has_play is registered and goes high the cycle after the edge, for exactly one cycle.
  - last_press captures buttons on the edge.
  - A multi-hot press is still captured as-is and will not compare equal.
- Play register: clear_reg sets it to 0; enable_reg loads last_press.
- LFSR: 8-bit Fibonacci, taps [7,5,4,3]. It shifts every cycle and reset_random reloads the seed. Random play = one-hot(lfsr[1:0]).
- RAM:
  - enable_ram writes the random play to ram[address].
  - clear_ram zeroes all words in one cycle and wins over a write in the same cycle.
  - Reads are combinational.
- Points: enable adds +1 and saturates at 2**POINTS_W-1.
- leds, registered (1-cycle latency):
  - out_sel 00 -> 0.
  - out_sel 01 -> ram[address].
  - out_sel 10 -> buttons.
  - out_sel 11 -> 0.
- Strobes arriving outside their intended state are obeyed literally; the datapath does not check control-unit state.

Optional Feature:
- CAKEGAME_FD_DEBUG_EN.
- Defined: adds outputs db_address[ADDR_W-1:0], db_play[3:0], db_expected[3:0] (ram[address]) and db_lfsr[7:0], all taken directly from the internal registers.
- Undefined: these ports and their logic do not exist. Core behaviour is identical either way.

Test Plan:
- Parameters MEM_DEPTH=4, SHOW_CYCLES=8, TIMEOUT_CYCLES=10, POINTS_W=3.
- Reset -> leds=0, points=0, has_play=0, timeout=0, end_mem_counter=0, correct_play=1.
- Hold enable_show_counter for 12 clocks after a clear -> half_show high on cycle 4 only, end_show high on cycle 8, count wraps so half_show is high again on cycle 12. Assert clear and enable together -> count=0.
- reset_random, then enable_ram at addresses 0..3 on consecutive cycles -> ram contents match a one-hot LFSR model. out_sel=01 -> leds equals ram[address] one cycle later.
- Hold buttons=4'b0010 for 5 cycles -> exactly one has_play pulse. enable_reg with ram[address]=0010 -> correct_play=1. Two enable_points_counter pulses -> points=2. Eight pulses -> points saturates at 7.
- enable_timeout_counter with no press -> timeout on cycle 10 and stays high. Press on cycle 6 -> count restarts and timeout is delayed.
- enable_ram and clear_ram together -> all words 0. Reset mid-count -> every counter is 0 on the next edge.
